// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Holds the default widths, the $zero register number, the default-width
// writeback entry type and the occupancy-counter width helper.
package wb_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 32;

    // Register 0 is hardwired to zero and must never be written.
    localparam int REG_ZERO = 0;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] num;
        logic [DATA_W_DEF-1:0] data;
    } wb_entry_t;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order circular buffer of pending register writes with a youngest-match search.
// Latency: push visible at head one edge later; search/head/flags combinational.
// Backpressure: none internally; caller must not push when full or pop when empty.
//
// Ports: clk/reset (sync, active-high); push + push_num/push_data; pop;
// head_num/head_data (oldest entry); full/empty/count; srch_num in,
// srch_hit/srch_data out (youngest valid entry whose num equals srch_num).
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [ADDR_W-1:0]          push_num,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    output logic [ADDR_W-1:0]          head_num,
    output logic [DATA_W-1:0]          head_data,
    output logic                       full,
    output logic                       empty,
    output logic [cnt_w(DEPTH)-1:0]    count,
    input  logic [ADDR_W-1:0]          srch_num,
    output logic                       srch_hit,
    output logic [DATA_W-1:0]          srch_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);

    logic [ADDR_W-1:0] num_q  [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  idx;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: only entries covered by count are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            num_q[wr_ptr]  <= push_num;
            data_q[wr_ptr] <= push_data;
        end
    end

    assign head_num  = num_q[rd_ptr];
    assign head_data = data_q[rd_ptr];
    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);

    // Walk entries oldest to youngest; a later match overrides an earlier
    // one, so the result is the youngest pending value.
    always_comb begin
        srch_hit  = 1'b0;
        srch_data = '0;
        idx       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PTR_W'(i);
            if ((CNT_W'(i) < count) && (num_q[idx] == srch_num)) begin
                srch_hit  = 1'b1;
                srch_data = data_q[idx];
            end
        end
    end

endmodule

// File: rtl/wb_write_sequencer.sv
// Merges ALU and load writeback results into the single register-file write port.
// Latency: accepted at edge N -> reg_wr_en high N+1..N+2 (empty FIFO, no hold).
// Backpressure: both sources stall when the FIFO is full; src1 has fixed priority over src0.
//
// Ports: clk/reset (sync, active-high); src0_*/src1_* valid/ready producers;
// wb_hold freezes draining; reg_wr_en/num/data registered write port;
// fwd_num query -> fwd_hit/fwd_data youngest pending value; pending_cnt occupancy.
module wb_write_sequencer
    import wb_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     src0_valid,
    output logic                     src0_ready,
    input  logic [ADDR_W-1:0]        src0_num,
    input  logic [DATA_W-1:0]        src0_data,
    input  logic                     src1_valid,
    output logic                     src1_ready,
    input  logic [ADDR_W-1:0]        src1_num,
    input  logic [DATA_W-1:0]        src1_data,
    input  logic                     wb_hold,
    output logic                     reg_wr_en,
    output logic [ADDR_W-1:0]        reg_wr_num,
    output logic [DATA_W-1:0]        reg_wr_data,
    input  logic [ADDR_W-1:0]        fwd_num,
    output logic                     fwd_hit,
    output logic [DATA_W-1:0]        fwd_data,
    output logic [cnt_w(DEPTH)-1:0]  pending_cnt
);

    logic              full;
    logic              empty;
    logic              acc0;
    logic              acc1;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] in_num;
    logic [DATA_W-1:0] in_data;
    logic [ADDR_W-1:0] head_num;
    logic [DATA_W-1:0] head_data;
    logic              q_hit;
    logic [DATA_W-1:0] q_data;

    // Ready depends on full only: a pop in the same cycle does not open a
    // slot early, which keeps ready off the drain path.
    assign src1_ready = !full;
    assign src0_ready = !full && !src1_valid;

    assign acc1    = src1_valid && src1_ready;
    assign acc0    = src0_valid && src0_ready;
    assign in_num  = acc1 ? src1_num  : src0_num;
    assign in_data = acc1 ? src1_data : src0_data;

    // Writes to $zero complete the handshake but are dropped here.
    assign push = (acc0 || acc1) && (in_num != ADDR_W'(REG_ZERO));
    assign pop  = !wb_hold && !empty;

    wb_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_num  (in_num),
        .push_data (in_data),
        .pop       (pop),
        .head_num  (head_num),
        .head_data (head_data),
        .full      (full),
        .empty     (empty),
        .count     (pending_cnt),
        .srch_num  (fwd_num),
        .srch_hit  (q_hit),
        .srch_data (q_data)
    );

    // Output stage: num/data hold their last value when no write issues.
    always_ff @(posedge clk) begin
        if (reset) begin
            reg_wr_en   <= 1'b0;
            reg_wr_num  <= '0;
            reg_wr_data <= '0;
        end else begin
            reg_wr_en <= pop;
            if (pop) begin
                reg_wr_num  <= head_num;
                reg_wr_data <= head_data;
            end
        end
    end

    // Anything still in the FIFO is younger than the output stage, so a
    // FIFO match wins; the output stage only counts while it is writing.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (fwd_num != ADDR_W'(REG_ZERO)) begin
            if (q_hit) begin
                fwd_hit  = 1'b1;
                fwd_data = q_data;
            end else if (reg_wr_en && (reg_wr_num == fwd_num)) begin
                fwd_hit  = 1'b1;
                fwd_data = reg_wr_data;
            end
        end
    end

endmodule

// File: tb/tb_wb_write_sequencer.sv
// Scoreboard bench for wb_write_sequencer: directed vectors push expected writes,
// a forked monitor pops and compares on every reg_wr_en cycle.
module tb_wb_write_sequencer;
    import wb_pkg::*;

    logic        clk;
    logic        reset;
    logic        src0_valid;
    logic        src0_ready;
    logic [4:0]  src0_num;
    logic [31:0] src0_data;
    logic        src1_valid;
    logic        src1_ready;
    logic [4:0]  src1_num;
    logic [31:0] src1_data;
    logic        wb_hold;
    logic        reg_wr_en;
    logic [4:0]  reg_wr_num;
    logic [31:0] reg_wr_data;
    logic [4:0]  fwd_num;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic [2:0]  pending_cnt;

    int checks;
    int errors;
    wb_entry_t exp_q[$];

    wb_write_sequencer #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .src0_valid  (src0_valid),
        .src0_ready  (src0_ready),
        .src0_num    (src0_num),
        .src0_data   (src0_data),
        .src1_valid  (src1_valid),
        .src1_ready  (src1_ready),
        .src1_num    (src1_num),
        .src1_data   (src1_data),
        .wb_hold     (wb_hold),
        .reg_wr_en   (reg_wr_en),
        .reg_wr_num  (reg_wr_num),
        .reg_wr_data (reg_wr_data),
        .fwd_num     (fwd_num),
        .fwd_hit     (fwd_hit),
        .fwd_data    (fwd_data),
        .pending_cnt (pending_cnt)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic expect_wr(input logic [4:0] num, input logic [31:0] data);
        wb_entry_t e;
        e.num  = num;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic monitor();
        wb_entry_t e;
        forever begin
            @(negedge clk);
            if (reg_wr_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got num=%0d data=%0h, expected no write",
                             reg_wr_num, reg_wr_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_num",  64'(reg_wr_num),  64'(e.num));
                    chk("wr_data", 64'(reg_wr_data), 64'(e.data));
                end
            end
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        src0_valid = 1'b0;
        src0_num   = '0;
        src0_data  = '0;
        src1_valid = 1'b0;
        src1_num   = '0;
        src1_data  = '0;
        wb_hold    = 1'b0;
        fwd_num    = '0;

        fork
            monitor();
            begin
                #200000;
                $display("FAIL watchdog: got timeout, expected completion");
                $fatal(1, "watchdog expired");
            end
        join_none

        tick();
        tick();
        reset = 1'b0;

        // Reset state
        fwd_num = 5'd5;
        at_neg();
        chk("rst_pending", 64'(pending_cnt), 64'(0));
        chk("rst_wr_en",   64'(reg_wr_en),   64'(0));
        chk("rst_rdy0",    64'(src0_ready),  64'(1));
        chk("rst_rdy1",    64'(src1_ready),  64'(1));
        chk("rst_fwd_hit", 64'(fwd_hit),     64'(0));

        // Single write
        tick();
        src0_valid = 1'b1; src0_num = 5'd5; src0_data = 32'hDEADBEEF;
        at_neg();
        chk("single_rdy0", 64'(src0_ready), 64'(1));
        tick();
        expect_wr(5'd5, 32'hDEADBEEF);
        src0_valid = 1'b0;
        at_neg();
        chk("single_pend1", 64'(pending_cnt), 64'(1));
        chk("single_en0",   64'(reg_wr_en),   64'(0));
        tick();
        at_neg();
        chk("single_en1",   64'(reg_wr_en),   64'(1));
        chk("single_pend0", 64'(pending_cnt), 64'(0));
        tick();
        at_neg();
        chk("single_en_off", 64'(reg_wr_en), 64'(0));

        // Priority: src1 first, then src0
        tick();
        src0_valid = 1'b1; src0_num = 5'd4; src0_data = 32'h22;
        src1_valid = 1'b1; src1_num = 5'd3; src1_data = 32'h11;
        at_neg();
        chk("prio_rdy0", 64'(src0_ready), 64'(0));
        chk("prio_rdy1", 64'(src1_ready), 64'(1));
        tick();
        expect_wr(5'd3, 32'h11);
        src1_valid = 1'b0;
        at_neg();
        chk("prio_rdy0_after", 64'(src0_ready), 64'(1));
        tick();
        expect_wr(5'd4, 32'h22);
        src0_valid = 1'b0;
        repeat (3) tick();

        // Full / backpressure
        wb_hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            src0_valid = 1'b1;
            src0_num   = 5'(10 + i);
            src0_data  = 32'hA0 + 32'(i);
            tick();
            expect_wr(5'(10 + i), 32'hA0 + 32'(i));
        end
        src0_valid = 1'b0;
        at_neg();
        chk("full_pend", 64'(pending_cnt), 64'(4));
        chk("full_rdy0", 64'(src0_ready),  64'(0));
        chk("full_rdy1", 64'(src1_ready),  64'(0));
        src1_valid = 1'b1; src1_num = 5'd14; src1_data = 32'hA4;
        tick();
        at_neg();
        chk("full_hold_pend", 64'(pending_cnt), 64'(4));
        wb_hold = 1'b0;
        #1;
        chk("full_nobypass_rdy1", 64'(src1_ready), 64'(0));
        tick();
        at_neg();
        chk("drain1_rdy1", 64'(src1_ready),  64'(1));
        chk("drain1_pend", 64'(pending_cnt), 64'(3));
        tick();
        expect_wr(5'd14, 32'hA4);
        src1_valid = 1'b0;
        at_neg();
        chk("pushpop_pend", 64'(pending_cnt), 64'(3));
        repeat (6) tick();
        chk("full_drained", 64'(pending_cnt), 64'(0));

        // Forwarding
        wb_hold = 1'b1;
        src0_valid = 1'b1; src0_num = 5'd7; src0_data = 32'hA;
        tick();
        expect_wr(5'd7, 32'hA);
        src0_data = 32'hB;
        tick();
        expect_wr(5'd7, 32'hB);
        src0_valid = 1'b0;
        fwd_num = 5'd7;
        at_neg();
        chk("fwd7_hit",  64'(fwd_hit),  64'(1));
        chk("fwd7_data", 64'(fwd_data), 64'(32'hB));
        fwd_num = 5'd8;
        #1;
        chk("fwd8_hit",  64'(fwd_hit),  64'(0));
        chk("fwd8_data", 64'(fwd_data), 64'(0));
        fwd_num = 5'd0;
        #1;
        chk("fwd0_hit", 64'(fwd_hit), 64'(0));
        fwd_num = 5'd7;
        wb_hold = 1'b0;
        tick();
        at_neg();
        chk("fwd_mix_data", 64'(fwd_data), 64'(32'hB));
        tick();
        at_neg();
        chk("fwd_out_hit",  64'(fwd_hit),     64'(1));
        chk("fwd_out_data", 64'(fwd_data),    64'(32'hB));
        chk("fwd_out_pend", 64'(pending_cnt), 64'(0));
        tick();
        at_neg();
        chk("fwd_gone_hit", 64'(fwd_hit), 64'(0));

        // $zero filter
        tick();
        src0_valid = 1'b1; src0_num = 5'd0; src0_data = 32'hFFFFFFFF;
        at_neg();
        chk("zero_rdy0", 64'(src0_ready), 64'(1));
        tick();
        src0_valid = 1'b0;
        at_neg();
        chk("zero_pend", 64'(pending_cnt), 64'(0));
        repeat (3) tick();

        // Reset mid-operation discards queued entries
        wb_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            src0_valid = 1'b1;
            src0_num   = 5'(20 + i);
            src0_data  = 32'hC0 + 32'(i);
            tick();
        end
        src0_valid = 1'b0;
        fwd_num = 5'd21;
        at_neg();
        chk("prerst_pend", 64'(pending_cnt), 64'(3));
        chk("prerst_hit",  64'(fwd_hit),     64'(1));
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        at_neg();
        chk("midrst_pend",  64'(pending_cnt), 64'(0));
        chk("midrst_wr_en", 64'(reg_wr_en),   64'(0));
        chk("midrst_rdy0",  64'(src0_ready),  64'(1));
        chk("midrst_rdy1",  64'(src1_ready),  64'(1));
        for (int n = 0; n < 32; n++) begin
            fwd_num = 5'(n);
            #1;
            chk("midrst_fwd_hit", 64'(fwd_hit), 64'(0));
        end
        wb_hold = 1'b0;
        repeat (4) tick();

        chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_write_sequencer.md
Name: wb_write_sequencer

Overview:
Writer side of the processor register file's single write port. Accepts writeback results from two producers: the ALU path (src0) and the load/long-latency path (src1). Each producer uses a valid/ready handshake. Results are buffered in an in-order FIFO and issued as at most one registered write per cycle (enable/number/data) to the register file. A combinational forwarding lookup lets hazard logic read pending, not-yet-written values.

Parameters:
DEPTH, 4, FIFO entries; power of two, >=2
DATA_W, 32, register data width
ADDR_W, 5, register number width (32 registers)

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  synchronous, active-high
src0_valid  in  1  ALU result valid
src0_ready  out  1  ALU result accepted this edge when valid&ready
src0_num  in  ADDR_W  destination register
src0_data  in  DATA_W  result
src1_valid  in  1  load result valid
src1_ready  out  1  load result accepted
src1_num  in  ADDR_W  destination register
src1_data  in  DATA_W  result
wb_hold  in  1  freeze drain (register file port unavailable)
reg_wr_en  out  1  write enable to register file
reg_wr_num  out  ADDR_W  write register number
reg_wr_data  out  DATA_W  write data
fwd_num  in  ADDR_W  forwarding query register
fwd_hit  out  1  pending write to fwd_num exists
fwd_data  out  DATA_W  youngest pending value for fwd_num
pending_cnt  out  $clog2(DEPTH+1)  FIFO occupancy (excludes output stage)

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high, sampled on posedge clk.
- Reset state:
  - FIFO pointers and count = 0.
  - reg_wr_en=0, reg_wr_num=0, reg_wr_data=0.
  - Buffered entries are discarded, including when reset is asserted mid-operation. No write is issued in the cycle after reset.
- Ready (combinational):
  - src1_ready = !full.
  - src0_ready = !full && !src1_valid. src1 has fixed priority, so at most one acceptance per edge.
- Enqueue: on acceptance, {num,data} is pushed at the tail.
  - num==0 is accepted (handshake completes) but not pushed; $zero is never written.
- Drain: each posedge with !wb_hold && !empty pops the head into the output registers and sets reg_wr_en=1.
  - Otherwise reg_wr_en=0; num/data hold their last value.
- Latency: accepted at edge N, empty FIFO, no hold → reg_wr_en=1 during cycle N+1→N+2; the register file captures it at edge N+2.
- Simultaneous push and pop: allowed; count unchanged.
  - Full with pop in the same cycle: ready stays 0. Ready is derived from full only; there is no bypass.
- Ordering: writes leave strictly in acceptance order. Same-register writes are not merged.
- Forwarding (combinational):
  - Search space: all valid FIFO entries plus the output stage while reg_wr_en=1.
  - fwd_hit=1 if any entry matches fwd_num; fwd_data is the youngest match (tail-most FIFO entry, then the output stage).
  - fwd_num==0 or no match → fwd_hit=0, fwd_data=0.
- Pointers wrap modulo DEPTH.
- full = (count==DEPTH); empty = (count==0).

Decomposition:
- Shared package (wb_pkg):
  - ADDR_W, DATA_W defaults
  - REG_ZERO constant
  - wb_entry_t struct {num, data}
  - count width function
- One natural sub-module: wb_fifo. It is a circular buffer with push/pop, full/empty/count, and a parallel youngest-match search output.
- The top level holds the arbitration, the $zero filter, the output register stage, and the merge of the output stage into the forward search.

Test Plan:
- Reset: assert reset 1 cycle with 3 entries queued under wb_hold → next cycle pending_cnt=0, reg_wr_en=0, src0_ready=src1_ready=1, fwd_hit=0 for all nums. No write follows after release.
- Single write: src0 {5, 0xDEADBEEF} accepted at edge N → reg_wr_en=1, reg_wr_num=5, reg_wr_data=0xDEADBEEF in cycle N+1; reg_wr_en=0 in cycle N+2; pending_cnt 1 then 0.
- Priority: src0 {4, 0x22} and src1 {3, 0x11} both valid → src0_ready=0 that cycle. Writes issue as reg 3 then reg 4 on consecutive cycles.
- Full/backpressure: wb_hold=1, push 4 entries → pending_cnt=4, both readies 0, src1 held valid. Drop wb_hold → one pop per cycle, src1 accepted on the first edge where full clears, order preserved.
- Forwarding: under wb_hold push {7, 0xA} then {7, 0xB} → fwd_num=7 gives hit=1, data=0xB. fwd_num=8 gives hit=0. fwd_num=0 gives hit=0.
- $zero filter: src0 {0, 0xFFFFFFFF} → handshake completes, pending_cnt unchanged, no reg_wr_en pulse.
